// File: rtl/traffic_signal_pkg.sv
// Shared lamp codes, fault codes and monitor state encoding for the traffic
// signal monitor and controller.
package traffic_signal_pkg;

  typedef logic [1:0] lamp_t;
  typedef logic [2:0] fault_code_t;

  localparam lamp_t RED     = 2'b00;
  localparam lamp_t YELLOW  = 2'b01;
  localparam lamp_t GREEN   = 2'b10;
  localparam lamp_t ILLEGAL = 2'b11;

  localparam fault_code_t FC_NONE         = 3'd0;
  localparam fault_code_t FC_ILLEGAL      = 3'd1;
  localparam fault_code_t FC_CONFLICT     = 3'd2;
  localparam fault_code_t FC_BAD_TRANS    = 3'd3;
  localparam fault_code_t FC_SHORT_YELLOW = 3'd4;
  localparam fault_code_t FC_SHORT_ALLRED = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-approach lamp sequence checker: flags illegal transitions and yellow
// phases that end before MIN_YELLOW consecutive cycles.
module lamp_seq_checker
  import traffic_signal_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  lamp_t cur_i,
  input  lamp_t prev_i,
  output logic  bad_trans_o,
  output logic  short_yellow_o
);

  logic [7:0] yel_run_q, yel_run_d;

  always_comb begin
    yel_run_d = (cur_i == YELLOW) ? sat_inc(yel_run_q) : '0;
    if (clear_i) yel_run_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) yel_run_q <= '0;
    else       yel_run_q <= yel_run_d;
  end

  // yel_run_q holds the length of the yellow run that ended on prev_i
  always_comb begin
    bad_trans_o = ((prev_i == GREEN)  && (cur_i == RED))    ||
                  ((prev_i == YELLOW) && (cur_i == GREEN))  ||
                  ((prev_i == RED)    && (cur_i == YELLOW));
    short_yellow_o = (prev_i == YELLOW) && (cur_i == RED) &&
                     (32'(yel_run_q) < MIN_YELLOW);
  end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Traffic signal conflict monitor: detects illegal lamp codes, conflicting
// greens/yellows, bad sequences and short clearance intervals, then latches.
module traffic_signal_monitor
  import traffic_signal_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned MIN_ALLRED = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Hwy,
  input  logic [1:0] Cnrty,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic [7:0] fault_count
);

  mon_state_t  state_q, state_d;
  lamp_t       prev_hwy_q, prev_cnrty_q;
  logic [7:0]  allred_q, allred_d;
  fault_code_t code_q, code_d;
  logic [7:0]  count_q, count_d;
  fault_code_t viol_code;

  logic counters_clr;
  logic hwy_bad, hwy_short_y, cn_bad, cn_short_y;
  logic illegal, conflict, short_allred;

  assign counters_clr = (state_q == ST_INIT);

  lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_hwy_chk (
    .clk_i          (clk),
    .rst_i          (reset),
    .clear_i        (counters_clr),
    .cur_i          (Hwy),
    .prev_i         (prev_hwy_q),
    .bad_trans_o    (hwy_bad),
    .short_yellow_o (hwy_short_y)
  );

  lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_cnrty_chk (
    .clk_i          (clk),
    .rst_i          (reset),
    .clear_i        (counters_clr),
    .cur_i          (Cnrty),
    .prev_i         (prev_cnrty_q),
    .bad_trans_o    (cn_bad),
    .short_yellow_o (cn_short_y)
  );

  always_comb begin
    allred_d = ((Hwy == RED) && (Cnrty == RED)) ? sat_inc(allred_q) : '0;
    if (counters_clr) allred_d = '0;
  end

  always_comb begin
    illegal      = (Hwy == ILLEGAL) || (Cnrty == ILLEGAL);
    conflict     = (Hwy != RED) && (Cnrty != RED);
    short_allred = (MIN_ALLRED > 0) &&
                   (((prev_hwy_q == RED)   && (Hwy == GREEN)) ||
                    ((prev_cnrty_q == RED) && (Cnrty == GREEN))) &&
                   (32'(allred_q) < MIN_ALLRED);
    viol_code = FC_NONE;
    if (illegal)                        viol_code = FC_ILLEGAL;
    else if (conflict)                  viol_code = FC_CONFLICT;
    else if (hwy_bad || cn_bad)         viol_code = FC_BAD_TRANS;
    else if (hwy_short_y || cn_short_y) viol_code = FC_SHORT_YELLOW;
    else if (short_allred)              viol_code = FC_SHORT_ALLRED;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:    state_d = ST_MONITOR;
      ST_MONITOR: if (viol_code != FC_NONE) state_d = ST_FAULT;
      ST_FAULT:   if (clr_fault) state_d = ST_INIT;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    fault       = (state_q == ST_FAULT);
    flash_en    = (state_q == ST_FAULT);
    fault_code  = code_q;
    fault_count = count_q;
  end

  // Fault code and count latch only on MONITOR->FAULT entry
  always_comb begin
    code_d  = code_q;
    count_d = count_q;
    if ((state_q == ST_MONITOR) && (viol_code != FC_NONE)) begin
      code_d  = viol_code;
      count_d = sat_inc(count_q);
    end else if ((state_q == ST_FAULT) && clr_fault) begin
      code_d = FC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_hwy_q   <= RED;
      prev_cnrty_q <= RED;
      allred_q     <= '0;
      code_q       <= FC_NONE;
      count_q      <= '0;
    end else begin
      prev_hwy_q   <= Hwy;
      prev_cnrty_q <= Cnrty;
      allred_q     <= allred_d;
      code_q       <= code_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor: default-parameter instance plus
// one with MIN_YELLOW=3, MIN_ALLRED=2, sharing the same stimulus.
module tb_traffic_signal_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Hwy = 2'b00;
  logic [1:0] Cnrty = 2'b00;
  logic       clr_fault = 1'b0;

  logic       d_fault, d_flash;
  logic [2:0] d_code;
  logic [7:0] d_count;
  logic       p_fault, p_flash;
  logic [2:0] p_code;
  logic [7:0] p_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_signal_monitor u_def (
    .clk         (clk),
    .reset       (reset),
    .Hwy         (Hwy),
    .Cnrty       (Cnrty),
    .clr_fault   (clr_fault),
    .fault       (d_fault),
    .fault_code  (d_code),
    .flash_en    (d_flash),
    .fault_count (d_count)
  );

  traffic_signal_monitor #(.MIN_YELLOW(3), .MIN_ALLRED(2)) u_par (
    .clk         (clk),
    .reset       (reset),
    .Hwy         (Hwy),
    .Cnrty       (Cnrty),
    .clr_fault   (clr_fault),
    .fault       (p_fault),
    .fault_code  (p_code),
    .flash_en    (p_flash),
    .fault_count (p_count)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic [1:0] hwy;
    logic [1:0] cnrty;
    logic       exp_fault;
    logic [2:0] exp_code;
    logic [7:0] exp_count;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic clr, input logic [1:0] h,
                              input logic [1:0] c, input logic f, input logic [2:0] code,
                              input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.clr = clr; v.hwy = h; v.cnrty = c;
    v.exp_fault = f; v.exp_code = code; v.exp_count = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h, input logic [1:0] c);
    Hwy = h; Cnrty = c; clr_fault = 1'b0; reset = 1'b0;
    step();
  endtask

  // Leaves both instances in MONITOR with prev samples and counters at zero.
  task automatic reset_pair();
    Hwy = 2'b00; Cnrty = 2'b00; clr_fault = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic chk_par(input string name, input logic f, input logic [2:0] code,
                         input logic [7:0] cnt);
    chk({name, ".fault"}, p_fault, f);
    chk({name, ".flash"}, p_flash, f);
    chk({name, ".code"},  p_code,  code);
    chk({name, ".count"}, p_count, cnt);
  endtask

  task automatic chk_def(input string name, input logic f, input logic [2:0] code,
                         input logic [7:0] cnt);
    chk({name, ".fault"}, d_fault, f);
    chk({name, ".flash"}, d_flash, f);
    chk({name, ".code"},  d_code,  code);
    chk({name, ".count"}, d_count, cnt);
  endtask

  initial begin
    int exp_cnt;
    logic [1:0] legal_h [6];
    logic [1:0] legal_c [6];

    vecs[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0, 0, 2'b10, 2'b00, 0, 0, 0);
    vecs[3]  = mk(0, 0, 2'b10, 2'b10, 1, 2, 1);
    vecs[4]  = mk(0, 0, 2'b10, 2'b10, 1, 2, 1);
    vecs[5]  = mk(0, 0, 2'b11, 2'b11, 1, 2, 1);
    vecs[6]  = mk(0, 1, 2'b11, 2'b11, 0, 0, 1);
    vecs[7]  = mk(0, 0, 2'b10, 2'b00, 0, 0, 1);
    vecs[8]  = mk(0, 0, 2'b00, 2'b00, 1, 3, 2);
    vecs[9]  = mk(0, 1, 2'b00, 2'b00, 0, 0, 2);
    vecs[10] = mk(0, 0, 2'b00, 2'b00, 0, 0, 2);
    vecs[11] = mk(0, 0, 2'b01, 2'b00, 1, 3, 3);
    vecs[12] = mk(0, 1, 2'b01, 2'b00, 0, 0, 3);
    vecs[13] = mk(0, 0, 2'b01, 2'b00, 0, 0, 3);
    vecs[14] = mk(0, 0, 2'b10, 2'b00, 1, 3, 4);
    vecs[15] = mk(1, 0, 2'b10, 2'b00, 0, 0, 0);
    vecs[16] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[17] = mk(0, 1, 2'b00, 2'b00, 0, 0, 0);
    vecs[18] = mk(0, 0, 2'b11, 2'b00, 1, 1, 1);

    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst; clr_fault = vecs[i].clr;
      Hwy = vecs[i].hwy;   Cnrty = vecs[i].cnrty;
      step();
      chk($sformatf("vec%0d", i), d_fault, vecs[i].exp_fault);
      chk($sformatf("vec%0d.flash", i), d_flash, vecs[i].exp_fault);
      chk($sformatf("vec%0d.code", i), d_code, vecs[i].exp_code);
      chk($sformatf("vec%0d.count", i), d_count, vecs[i].exp_count);
    end

    // Legal cycle, default parameters
    legal_h = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    legal_c = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    reset_pair();
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 6; k++) begin
        drive(legal_h[k], legal_c[k]);
        chk($sformatf("legal r%0d k%0d", r, k), d_fault, 0);
      end
    end
    chk("legal.count", d_count, 0);

    // Illegal + conflict, then clear with the violation still present
    reset_pair();
    drive(2'b11, 2'b01);
    chk_def("illegal_conflict", 1, 1, 1);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk_def("clr_with_viol", 0, 0, 1);
    drive(2'b11, 2'b01);
    chk_def("init_no_check", 0, 0, 1);
    drive(2'b00, 2'b01);
    chk_def("post_init_mon", 0, 0, 1);
    drive(2'b00, 2'b00);
    chk_def("post_init_y2r", 0, 0, 1);

    // MIN_YELLOW=3: direct G->R
    reset_pair();
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b10, 2'b00);
    chk_par("par_r2g_ok", 0, 0, 0);
    drive(2'b00, 2'b00);
    chk_par("par_g2r", 1, 3, 1);

    // MIN_YELLOW=3: exactly 3 yellows is fine, 2 is short
    reset_pair();
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b10, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
    chk_par("par_yellow3_ok", 0, 0, 0);
    drive(2'b00, 2'b00);
    drive(2'b10, 2'b00);
    chk_par("par_allred2_ok", 0, 0, 0);
    drive(2'b01, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
    chk_par("par_short_yellow", 1, 4, 1);

    // MIN_ALLRED=2: only one all-red cycle before Hwy goes green
    reset_pair();
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b10);
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b00);
    chk_par("par_cn_y2r_ok", 0, 0, 0);
    drive(2'b10, 2'b00);
    chk_par("par_short_allred", 1, 5, 1);
    drive(2'b10, 2'b10);
    chk_par("par_fault_hold", 1, 5, 1);
    reset = 1'b1;
    clr_fault = 1'b1;
    step();
    chk_par("par_reset_in_fault", 0, 0, 0);
    reset = 1'b0;
    clr_fault = 1'b0;
    step();
    chk_par("par_after_reset", 0, 0, 0);

    // Saturation of fault_count
    reset_pair();
    for (int i = 0; i < 300; i++) begin
      drive(2'b11, 2'b00);
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      if (i < 3 || i > 252) begin
        chk($sformatf("sat%0d.fault", i), d_fault, 1);
        chk($sformatf("sat%0d.count", i), d_count, exp_cnt);
      end
      clr_fault = 1'b1;
      step();
      clr_fault = 1'b0;
      drive(2'b00, 2'b00);
    end
    chk("sat.final", d_count, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
